// File: rtl/data_ram_arbiter_pkg.sv
// Shared constants and types for the data RAM arbiter.
// Mirrors the legacy define.v encodings and bus levels.
package data_ram_arbiter_pkg;

  localparam int DATA_SIZE = 32;

  localparam logic [DATA_SIZE-1:0] DATA_BUS_RESET = '0;

  localparam logic DC_READ_ACCEPT  = 1'b1;
  localparam logic DC_WRITE_ACCEPT = 1'b1;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_ACCESS = 2'd1;
  localparam logic [1:0] ARB_RESP   = 2'd2;

  localparam logic ARB_PORT0 = 1'b0;
  localparam logic ARB_PORT1 = 1'b1;

  typedef struct packed {
    logic id;
    logic we;
  } arb_req_t;

  function automatic logic pick_p1(
    input logic p0_req,
    input logic p1_req,
    input logic sat
  );
    return p1_req & (~p0_req | sat);
  endfunction

endpackage

// File: rtl/data_ram_arbiter_starve_counter.sv
// Saturating count of port-0 wins while port 1 waits.
// sat_o forces the next contested grant to port 1.
module arb_starve_counter
  import data_ram_arbiter_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam logic [3:0] LIM = 4'(LIMIT);

  logic [3:0] cnt_q, cnt_d;

  assign sat_o = (cnt_q == LIM);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !sat_o) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Two-port arbiter for the single-port data RAM.
// IDLE -> ACCESS -> RESP per transaction; done pulses in RESP.
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DATA_SIZE,
  parameter int DATA_W       = DATA_SIZE,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_done,
  output logic [DATA_W-1:0] p0_rdata,
  output logic              p0_stall,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_done,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              ram_re,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam logic [DATA_W-1:0] RD_RST =
    DATA_W'(DATA_BUS_RESET);

  logic [1:0]        state_q, state_d;
  arb_req_t          lat_q, lat_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic [DATA_W-1:0] rd0_q, rd0_d;
  logic [DATA_W-1:0] rd1_q, rd1_d;

  logic st_idle, st_acc, st_resp;
  logic any_req, gnt_p1;
  logic sat, inc, clr;

  assign st_idle = (state_q == ARB_IDLE);
  assign st_acc  = (state_q == ARB_ACCESS);
  assign st_resp = (state_q == ARB_RESP);

  assign any_req = p0_req | p1_req;
  assign gnt_p1  = pick_p1(p0_req, p1_req, sat);

  assign inc = st_idle & p0_req & p1_req & ~gnt_p1;
  assign clr = st_idle & (~p1_req | gnt_p1);

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst),
    .inc_i (inc),
    .clr_i (clr),
    .sat_o (sat)
  );

  // Enables are decoded from reset-cleared state so reset drops them at once.
  assign ram_re = (st_acc & ~lat_q.we) ?
    DC_READ_ACCEPT : ~DC_READ_ACCEPT;
  assign ram_we = (st_acc & lat_q.we) ?
    DC_WRITE_ACCEPT : ~DC_WRITE_ACCEPT;

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;

  assign p0_done  = done0_q;
  assign p1_done  = done1_q;
  assign p0_rdata = rd0_q;
  assign p1_rdata = rd1_q;
  assign p0_stall = p0_req & ~done0_q;

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    unique case (1'b1)
      st_idle: begin
        if (any_req) begin
          state_d  = ARB_ACCESS;
          lat_d.id = gnt_p1 ? ARB_PORT1 : ARB_PORT0;
          lat_d.we = gnt_p1 ? p1_we : p0_we;
          addr_d   = gnt_p1 ? p1_addr : p0_addr;
          wdata_d  = gnt_p1 ? p1_wdata : p0_wdata;
        end
      end
      st_acc: begin
        state_d = ARB_RESP;
        if (lat_q.id == ARB_PORT1) begin
          done1_d = 1'b1;
          if (!lat_q.we) rd1_d = ram_rdata;
        end else begin
          done0_d = 1'b1;
          if (!lat_q.we) rd0_d = ram_rdata;
        end
      end
      st_resp: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      lat_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      rd0_q   <= RD_RST;
      rd1_q   <= RD_RST;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
    end
  end

endmodule
